// File: rtl/mem_stage_pkg.sv
// Constants shared across the MEM stage: load-op encoding, side-band widths,
// exception array offsets and the forwarding bundle toward ID.
package mem_stage_pkg;

  // One-hot load op bit positions: {ld_w, ld_hu, ld_h, ld_bu, ld_b}
  localparam int LD_OP_W = 5;
  localparam int LD_B    = 0;
  localparam int LD_BU   = 1;
  localparam int LD_H    = 2;
  localparam int LD_HU   = 3;
  localparam int LD_W    = 4;

  localparam int EX_ZIP_W  = 87;
  localparam int TLB_ZIP_W = 10;
  localparam int TLB_EXC_W = 8;

  // ex_zip[7:0] is the exception/ertn flag array; the rest is payload for WB.
  localparam int EX_FLAG_MSB  = 7;
  localparam int EARRAY_ADEF  = 0;
  localparam int EARRAY_INT   = 1;
  localparam int EARRAY_SYS   = 2;
  localparam int EARRAY_BRK   = 3;
  localparam int EARRAY_INE   = 4;
  localparam int EARRAY_ALE   = 5;
  localparam int EARRAY_ERTN  = 6;
  localparam int EARRAY_ADEM  = 7;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam int TLB_REFETCH_BIT = 0;
  localparam int DROP_CNT_W_DEF  = 2;

  // MSB carries a pending CSR read so ID can stall CSR consumers too.
  typedef struct packed {
    logic        csr_re;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } ms_fwd_t;

  function automatic logic is_load(input logic [LD_OP_W-1:0] op);
    return |op;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the byte/half lane from the vaddr offset and
// sign- or zero-extends it; words pass through unchanged.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] i_ld_op,
  input  logic [1:0]         i_offset,
  input  logic [31:0]        i_rdata,
  output logic [31:0]        o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wdata = i_rdata;
    if (i_ld_op[LD_B])
      o_wdata = {{24{w_byte[7]}}, w_byte};
    else if (i_ld_op[LD_BU])
      o_wdata = {24'd0, w_byte};
    else if (i_ld_op[LD_H])
      o_wdata = {{16{w_half[15]}}, w_half};
    else if (i_ld_op[LD_HU])
      o_wdata = {16'd0, w_half};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: waits for data-SRAM responses, aligns load data and hands results to WB.
// Responses belonging to flushed requests are swallowed by a small drop counter.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [31:0]          es_pc,
  input  logic [31:0]          es_result,
  input  logic                 es_rf_we,
  input  logic [4:0]           es_rf_waddr,
  input  logic [LD_OP_W-1:0]   es_ld_op,
  input  logic                 es_mem_req,
  input  logic                 es_csr_re,
  input  logic [EX_ZIP_W-1:0]  es_ex_zip,
  input  logic [TLB_ZIP_W-1:0] es_tlb_zip,
  input  logic [TLB_EXC_W-1:0] es_tlb_exc,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 wb_flush,
  output logic                 ms_to_ws_valid,
  output logic [31:0]          ms_pc,
  output logic [31:0]          ms_result,
  output logic [31:0]          ms_rf_wdata,
  output logic                 ms_rf_we,
  output logic [4:0]           ms_rf_waddr,
  output logic                 ms_csr_re,
  output logic [EX_ZIP_W-1:0]  ms_ex_zip,
  output logic [TLB_ZIP_W-1:0] ms2ws_tlb_zip,
  output logic [TLB_EXC_W-1:0] ms2ws_tlb_exc,
  output logic                 ms_ex,
  output logic [38:0]          ms_fwd_zip,
  output logic                 ms_ld_block
);

  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  logic                 r_ms_valid;
  logic [31:0]          r_pc;
  logic [31:0]          r_result;
  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [LD_OP_W-1:0]   r_ld_op;
  logic                 r_mem_req;
  logic                 r_csr_re;
  logic [EX_ZIP_W-1:0]  r_ex_zip;
  logic [TLB_ZIP_W-1:0] r_tlb_zip;
  logic [TLB_EXC_W-1:0] r_tlb_exc;
  logic                 r_buf_valid;
  logic [31:0]          r_buf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic        w_wait_data;
  logic        w_data_hit;
  logic        w_ready_go;
  logic        w_capture;
  logic        w_handoff;
  logic        w_drop_inc;
  logic        w_drop_dec;
  logic [31:0] w_ld_rdata;
  logic [31:0] w_ld_wdata;
  ms_fwd_t     w_fwd;

  // A response only belongs to the current instruction once all stale ones are drained.
  assign w_wait_data    = r_ms_valid & r_mem_req & ~r_buf_valid;
  assign w_data_hit     = data_sram_data_ok & (r_drop_cnt == '0);
  assign w_ready_go     = ~w_wait_data | w_data_hit;
  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~wb_flush;
  assign w_capture      = es_to_ms_valid & ms_allowin;
  assign w_handoff      = ms_to_ws_valid & ws_allowin;

  assign w_drop_inc = wb_flush & w_wait_data & ~data_sram_data_ok;
  assign w_drop_dec = data_sram_data_ok & (r_drop_cnt != '0);

  always_ff @(posedge clk) begin
    if (!resetn)
      r_ms_valid <= 1'b0;
    else if (wb_flush)
      r_ms_valid <= 1'b0;
    else if (ms_allowin)
      r_ms_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc       <= '0;
      r_result   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_ld_op    <= '0;
      r_mem_req  <= 1'b0;
      r_csr_re   <= 1'b0;
      r_ex_zip   <= '0;
      r_tlb_zip  <= '0;
      r_tlb_exc  <= '0;
    end else if (w_capture) begin
      r_pc       <= es_pc;
      r_result   <= es_result;
      r_rf_we    <= es_rf_we;
      r_rf_waddr <= es_rf_waddr;
      r_ld_op    <= es_ld_op;
      r_mem_req  <= es_mem_req;
      r_csr_re   <= es_csr_re;
      r_ex_zip   <= es_ex_zip;
      r_tlb_zip  <= es_tlb_zip;
      r_tlb_exc  <= es_tlb_exc;
    end
  end

  // Holds load data that arrived while WB was stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (wb_flush || w_handoff) begin
      r_buf_valid <= 1'b0;
    end else if (w_wait_data && w_data_hit && !ws_allowin) begin
      r_buf_valid <= 1'b1;
      r_buf       <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      r_drop_cnt <= '0;
    else if (w_drop_inc && !w_drop_dec)
      r_drop_cnt <= r_drop_cnt + DROP_ONE;
    else if (w_drop_dec && !w_drop_inc)
      r_drop_cnt <= r_drop_cnt - DROP_ONE;
  end

  assign w_ld_rdata = r_buf_valid ? r_buf : data_sram_rdata;

  mem_load_align u_load_align (
    .i_ld_op  (r_ld_op),
    .i_offset (r_result[1:0]),
    .i_rdata  (w_ld_rdata),
    .o_wdata  (w_ld_wdata)
  );

  assign ms_rf_wdata   = is_load(r_ld_op) ? w_ld_wdata : r_result;
  assign ms_pc         = r_pc;
  assign ms_result     = r_result;
  assign ms_rf_we      = r_rf_we;
  assign ms_rf_waddr   = r_rf_waddr;
  assign ms_csr_re     = r_csr_re;
  assign ms_ex_zip     = r_ex_zip;
  assign ms2ws_tlb_zip = r_tlb_zip;
  assign ms2ws_tlb_exc = r_tlb_exc;

  assign ms_ex = r_ms_valid & ((|r_ex_zip[EX_FLAG_MSB:0]) | (|r_tlb_exc) | r_tlb_zip[TLB_REFETCH_BIT]);

  assign ms_ld_block = w_wait_data & is_load(r_ld_op) & ~w_data_hit;

  assign w_fwd.csr_re   = r_csr_re & r_ms_valid;
  assign w_fwd.rf_we    = r_rf_we & r_ms_valid;
  assign w_fwd.rf_waddr = r_rf_waddr;
  assign w_fwd.rf_wdata = ms_rf_wdata;
  assign ms_fwd_zip     = w_fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, data-wait stalls, WB back-pressure
// buffering, stale-response dropping after flush, exception flagging and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc, es_result;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [4:0]  es_ld_op;
  logic        es_mem_req;
  logic        es_csr_re;
  logic [86:0] es_ex_zip;
  logic [9:0]  es_tlb_zip;
  logic [7:0]  es_tlb_exc;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc, ms_result, ms_rf_wdata;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic        ms_csr_re;
  logic [86:0] ms_ex_zip;
  logic [9:0]  ms2ws_tlb_zip;
  logic [7:0]  ms2ws_tlb_exc;
  logic        ms_ex;
  logic [38:0] ms_fwd_zip;
  logic        ms_ld_block;

  localparam logic [4:0] OP_B  = 5'b00001;
  localparam logic [4:0] OP_BU = 5'b00010;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b10000;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_result         (es_result),
    .es_rf_we          (es_rf_we),
    .es_rf_waddr       (es_rf_waddr),
    .es_ld_op          (es_ld_op),
    .es_mem_req        (es_mem_req),
    .es_csr_re         (es_csr_re),
    .es_ex_zip         (es_ex_zip),
    .es_tlb_zip        (es_tlb_zip),
    .es_tlb_exc        (es_tlb_exc),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .wb_flush          (wb_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_result         (ms_result),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_csr_re         (ms_csr_re),
    .ms_ex_zip         (ms_ex_zip),
    .ms2ws_tlb_zip     (ms2ws_tlb_zip),
    .ms2ws_tlb_exc     (ms2ws_tlb_exc),
    .ms_ex             (ms_ex),
    .ms_fwd_zip        (ms_fwd_zip),
    .ms_ld_block       (ms_ld_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present one instruction from EX for a single cycle; it is captured at the edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] res,
                       input logic [4:0] op, input logic req);
    es_pc = pc;
    es_result = res;
    es_ld_op = op;
    es_mem_req = req;
    es_to_ms_valid = 1'b1;
    settle();
    chk("allowin_at_issue", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [4:0] op,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(32'h1c00_0100, addr, op, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rdata;
    settle();
    chk({tag, "_valid"}, ms_to_ws_valid, 1'b1);
    chk({tag, "_wdata"}, ms_rf_wdata, exp);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk({tag, "_drained"}, ms_to_ws_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_pc = '0; es_result = '0; es_rf_we = 1'b1; es_rf_waddr = 5'd5;
    es_ld_op = '0; es_mem_req = 1'b0; es_csr_re = 1'b0;
    es_ex_zip = '0; es_tlb_zip = '0; es_tlb_exc = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ws_allowin = 1'b1; wb_flush = 1'b0;
    tick(); tick();

    chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ms_ex", ms_ex, 1'b0);
    chk("rst_ld_block", ms_ld_block, 1'b0);
    chk("rst_pc", ms_pc, 32'h0);
    chk("rst_wdata", ms_rf_wdata, 32'h0);
    chk("rst_fwd", ms_fwd_zip, 39'h0);
    resetn = 1'b1;
    tick();

    // ld_b, data next cycle: 1-cycle latency, sign-extended top byte
    issue(32'h1c00_0000, 32'h0000_1003, OP_B, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8012_3456;
    settle();
    chk("ldb_valid", ms_to_ws_valid, 1'b1);
    chk("ldb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
    chk("ldb_fwd", ms_fwd_zip, {1'b0, 1'b1, 5'd5, 32'hFFFF_FF80});
    chk("ldb_no_block", ms_ld_block, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("ldb_gone", ms_to_ws_valid, 1'b0);

    // ld_hu, data 3 cycles late
    issue(32'h1c00_0004, 32'h0000_2002, OP_HU, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ldhu_stall_valid", ms_to_ws_valid, 1'b0);
      chk("ldhu_stall_block", ms_ld_block, 1'b1);
      chk("ldhu_stall_allowin", ms_allowin, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8001_FFFF;
    settle();
    chk("ldhu_valid", ms_to_ws_valid, 1'b1);
    chk("ldhu_wdata", ms_rf_wdata, 32'h0000_8001);
    tick();
    data_sram_data_ok = 1'b0;

    // alignment table
    do_load("ldbu_1", 32'h0000_0001, OP_BU, 32'h1122_8344, 32'h0000_0083);
    do_load("ldb_1",  32'h0000_0001, OP_B,  32'h1122_8344, 32'hFFFF_FF83);
    do_load("ldh_0",  32'h0000_0000, OP_H,  32'h1234_8765, 32'hFFFF_8765);
    do_load("ldh_2",  32'h0000_0002, OP_H,  32'h7654_8000, 32'h0000_7654);
    do_load("ldbu_2", 32'h0000_0002, OP_BU, 32'h00AB_0000, 32'h0000_00AB);
    do_load("ldb_0",  32'h0000_0000, OP_B,  32'hFFFF_FF7F, 32'h0000_007F);
    do_load("ldw_0",  32'h0000_0000, OP_W,  32'hA5A5_1234, 32'hA5A5_1234);

    // ld_w with WB stalled for 2 cycles: data buffered
    issue(32'h1c00_0008, 32'h0000_3000, OP_W, 1'b1);
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("buf_arrive_valid", ms_to_ws_valid, 1'b1);
    chk("buf_arrive_allowin", ms_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    settle();
    chk("buf_hold_valid", ms_to_ws_valid, 1'b1);
    chk("buf_hold_wdata", ms_rf_wdata, 32'hDEAD_BEEF);
    chk("buf_hold_block", ms_ld_block, 1'b0);
    tick();
    ws_allowin = 1'b1;
    settle();
    chk("buf_deliver_wdata", ms_rf_wdata, 32'hDEAD_BEEF);
    chk("buf_deliver_allowin", ms_allowin, 1'b1);
    tick();
    settle();
    chk("buf_done", ms_to_ws_valid, 1'b0);

    // flush while waiting: next response belongs to the flushed load
    issue(32'h1c00_000c, 32'h0000_4000, OP_W, 1'b1);
    wb_flush = 1'b1;
    settle();
    chk("flush_valid", ms_to_ws_valid, 1'b0);
    tick();
    wb_flush = 1'b0;
    issue(32'h1c00_0010, 32'h0000_4004, OP_W, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBAD0_BAD0;
    settle();
    chk("drop_stale_valid", ms_to_ws_valid, 1'b0);
    chk("drop_stale_block", ms_ld_block, 1'b1);
    tick();
    data_sram_rdata = 32'h600D_F00D;
    settle();
    chk("drop_own_valid", ms_to_ws_valid, 1'b1);
    chk("drop_own_wdata", ms_rf_wdata, 32'h600D_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    // exception side-band
    es_csr_re = 1'b1;
    es_rf_waddr = 5'd17;
    es_ex_zip = 87'h0_1234_5678_9ABC_DEF0_0020;
    es_tlb_zip = 10'h2A6;
    es_tlb_exc = 8'h00;
    issue(32'h1c00_0020, 32'h0000_5001, 5'b00000, 1'b0);
    settle();
    chk("ale_ms_ex", ms_ex, 1'b1);
    chk("ale_valid", ms_to_ws_valid, 1'b1);
    chk("ale_zip", ms_ex_zip, 87'h0_1234_5678_9ABC_DEF0_0020);
    chk("ale_tlb_zip", ms2ws_tlb_zip, 10'h2A6);
    chk("ale_pc", ms_pc, 32'h1c00_0020);
    chk("ale_result", ms_result, 32'h0000_5001);
    chk("ale_wdata", ms_rf_wdata, 32'h0000_5001);
    chk("ale_fwd", ms_fwd_zip, {1'b1, 1'b1, 5'd17, 32'h0000_5001});
    es_csr_re = 1'b0;
    es_ex_zip = 87'h100;
    es_tlb_zip = 10'h000;
    issue(32'h1c00_0024, 32'h0000_0000, 5'b00000, 1'b0);
    settle();
    chk("noflag_ms_ex", ms_ex, 1'b0);
    es_ex_zip = '0;
    es_tlb_exc = 8'h04;
    issue(32'h1c00_0028, 32'h0000_0000, 5'b00000, 1'b0);
    settle();
    chk("tlbexc_ms_ex", ms_ex, 1'b1);
    chk("tlbexc_pass", ms2ws_tlb_exc, 8'h04);
    es_tlb_exc = 8'h00;
    es_tlb_zip = 10'h001;
    issue(32'h1c00_002c, 32'h0000_0000, 5'b00000, 1'b0);
    settle();
    chk("refetch_ms_ex", ms_ex, 1'b1);
    es_tlb_zip = 10'h000;
    es_rf_waddr = 5'd5;
    tick();
    settle();
    chk("ex_idle_ms_ex", ms_ex, 1'b0);

    // reset while a load waits with a stale drop pending
    issue(32'h1c00_0030, 32'h0000_6000, OP_W, 1'b1);
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    issue(32'h1c00_0034, 32'h0000_6004, OP_W, 1'b1);
    resetn = 1'b0;
    tick();
    chk("rstmid_valid", ms_to_ws_valid, 1'b0);
    chk("rstmid_block", ms_ld_block, 1'b0);
    chk("rstmid_pc", ms_pc, 32'h0);
    resetn = 1'b1;
    settle();
    chk("rstmid_after_valid", ms_to_ws_valid, 1'b0);
    issue(32'h1c00_0038, 32'h0000_6008, OP_W, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_0001;
    settle();
    chk("rstdrop_valid", ms_to_ws_valid, 1'b1);
    chk("rstdrop_wdata", ms_rf_wdata, 32'hCAFE_0001);
    tick();
    data_sram_data_ok = 1'b0;

    // reset while data sits in the buffer
    issue(32'h1c00_0040, 32'h0000_7000, OP_W, 1'b1);
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_F00D;
    tick();
    data_sram_data_ok = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    ws_allowin = 1'b1;
    settle();
    chk("rstbuf_valid", ms_to_ws_valid, 1'b0);
    issue(32'h1c00_0044, 32'h0000_7004, OP_W, 1'b1);
    settle();
    chk("rstbuf_wait_valid", ms_to_ws_valid, 1'b0);
    chk("rstbuf_wait_block", ms_ld_block, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1357_9BDF;
    settle();
    chk("rstbuf_wdata", ms_rf_wdata, 32'h1357_9BDF);
    tick();
    data_sram_data_ok = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
